// File: rtl/alu_group_sequencer_pkg.sv
// Shared constants for the ALU group sequencer.
// Holds the instruction group/mode codes, ALU opcodes, operand-source and
// address-select codes, the sequencer state encoding, the one-hot phase
// patterns and the registered control bundle driven by the sequencer.
package alu_group_sequencer_pkg;

    // Instruction groups
    localparam logic [1:0] GROUP_ARITHMETIC_LOGIC = 2'b01;

    // ALU addressing modes
    localparam logic [1:0] MODE_ALU_REG_REG   = 2'd0;
    localparam logic [1:0] MODE_ALU_REG_U4    = 2'd1;
    localparam logic [1:0] MODE_ALU_REGB_U8   = 2'd2;
    localparam logic [1:0] MODE_ALU_REGA_U8RB = 2'd3;

    // ALU opcodes
    localparam logic [3:0] ALU_OPX_ADD = 4'h0;
    localparam logic [3:0] ALU_OPX_SUB = 4'h1;
    localparam logic [3:0] ALU_OPX_AND = 4'h2;
    localparam logic [3:0] ALU_OPX_OR  = 4'h3;
    localparam logic [3:0] ALU_OPX_XOR = 4'h4;
    localparam logic [3:0] ALU_OPX_MOV = 4'h5;
    localparam logic [3:0] ALU_OPX_CMP = 4'h6;

    // ALU operand sources
    localparam logic [1:0] ALUA_SRCX_NONE  = 2'd0;
    localparam logic [1:0] ALUA_SRCX_REG_A = 2'd1;

    localparam logic [2:0] ALUB_SRCX_NONE  = 3'd0;
    localparam logic [2:0] ALUB_SRCX_REG_B = 3'd1;
    localparam logic [2:0] ALUB_SRCX_U4    = 3'd2;
    localparam logic [2:0] ALUB_SRCX_U8    = 3'd3;
    localparam logic [2:0] ALUB_SRCX_U8H   = 3'd4;

    // Register-file address selects
    localparam logic [2:0] REGA_ADDRX_NONE = 3'd0;
    localparam logic [2:0] REGA_ADDRX_RA   = 3'd1;
    localparam logic [2:0] REGA_ADDRX_RB   = 3'd2;

    localparam logic [1:0] REGB_ADDRX_NONE = 2'd0;
    localparam logic [1:0] REGB_ADDRX_RB   = 2'd1;

    // Sequencer state and one-hot phase flags {fetch, decode, execute, commit}
    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWait,
        StCommit
    } seq_state_e;

    localparam logic [3:0] PhFetch   = 4'b1000;
    localparam logic [3:0] PhDecode  = 4'b0100;
    localparam logic [3:0] PhExecute = 4'b0010;
    localparam logic [3:0] PhCommit  = 4'b0001;

    // Registered register-file / ALU-source controls
    typedef struct packed {
        logic       rega_en;
        logic       regb_en;
        logic       rega_wen;
        logic       ccl_ld;
        logic [2:0] rega_addrx;
        logic [1:0] regb_addrx;
        logic [1:0] alua_srcx;
        logic [2:0] alub_srcx;
    } ctrl_t;

    function automatic logic is_alu_group(input logic [1:0] grp);
        return grp == GROUP_ARITHMETIC_LOGIC;
    endfunction

endpackage

// File: rtl/alu_mode_decode.sv
// Combinational ALU-group mode/opcode decoder.
// Ports:
//   mode       - addressing mode field of the latched instruction
//   opx        - ALU opcode field of the latched instruction
//   alub_srcx  - ALU B-operand source for the mode
//   rega_addrx - port-A address select for the mode
//   regb_en    - register port B is read in EXECUTE
//   rega_wen   - result is written back in COMMIT (not for CMP_OPX)
//   ccl_ld     - condition codes are loaded in COMMIT (not for MOV)
module alu_mode_decode
    import alu_group_sequencer_pkg::*;
#(
    parameter int unsigned      OPX_W   = 4,
    parameter logic [OPX_W-1:0] CMP_OPX = OPX_W'(ALU_OPX_CMP)
) (
    input  logic [1:0]       mode,
    input  logic [OPX_W-1:0] opx,
    output logic [2:0]       alub_srcx,
    output logic [2:0]       rega_addrx,
    output logic             regb_en,
    output logic             rega_wen,
    output logic             ccl_ld
);

    always_comb begin
        alub_srcx  = ALUB_SRCX_NONE;
        rega_addrx = REGA_ADDRX_RA;
        regb_en    = 1'b0;
        unique case (mode)
            MODE_ALU_REG_REG: begin
                regb_en   = 1'b1;
                alub_srcx = ALUB_SRCX_REG_B;
            end
            MODE_ALU_REG_U4: begin
                alub_srcx = ALUB_SRCX_U4;
            end
            MODE_ALU_REGB_U8: begin
                // The 8-bit immediate spans both arg fields, so port A uses RB.
                alub_srcx  = ALUB_SRCX_U8;
                rega_addrx = REGA_ADDRX_RB;
            end
            MODE_ALU_REGA_U8RB: begin
                regb_en   = 1'b1;
                alub_srcx = ALUB_SRCX_U8H;
            end
            default: ;
        endcase
    end

    assign rega_wen = (opx != CMP_OPX);
    assign ccl_ld   = (opx != OPX_W'(ALU_OPX_MOV));

endmodule

// File: rtl/alu_group_sequencer.sv
// ALU group sequencer: FETCH/DECODE/EXECUTE/[WAIT]/COMMIT phase sequencer
// that accepts instructions over a valid/ready handshake and drives the
// register-file, ALU-source and condition-code controls.
// Ports:
//   CLK, RESET          - clock, asynchronous active-high reset
//   INSTRUCTION         - {group[2], opx[OPX_W], mode[2], argA[ARG_W], argB[ARG_W]}
//   INSTR_VALID/READY   - instruction handshake
//   STALL               - freezes state and outputs, forces INSTR_READY low
//   ALU_BUSY            - ALU still computing (multicycle build only)
//   FETCH..COMMIT       - one-hot phase flags (EXECUTE stays high in WAIT)
//   REGA_*/REGB_*       - register-file controls; REGB_WEN is always 0
//   ALU_OPX, ALUA_SRCX, ALUB_SRCX, CCL_LD - ALU controls
//   ARGA_X, ARGB_X      - argument fields of the last legal instruction
//   ILLEGAL             - pulse in DECODE when the word is not an ALU-group word
//   TIMEOUT             - pulse after an aborted ALU wait
// Build option: define ALU_MULTICYCLE_EN to add the ALU_BUSY wait state with
// a MAX_WAIT abort; without it ALU_BUSY is ignored and TIMEOUT stays 0.
module alu_group_sequencer
    import alu_group_sequencer_pkg::*;
#(
    parameter int unsigned      OPX_W    = 4,
    parameter int unsigned      ARG_W    = 4,
    parameter logic [OPX_W-1:0] CMP_OPX  = OPX_W'(ALU_OPX_CMP),
    parameter int unsigned      MAX_WAIT = 15
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [2+OPX_W+2+2*ARG_W-1:0]  INSTRUCTION,
    input  logic                          INSTR_VALID,
    output logic                          INSTR_READY,
    input  logic                          STALL,
    input  logic                          ALU_BUSY,
    output logic                          FETCH,
    output logic                          DECODE,
    output logic                          EXECUTE,
    output logic                          COMMIT,
    output logic                          REGA_EN,
    output logic                          REGB_EN,
    output logic                          REGA_WEN,
    output logic                          REGB_WEN,
    output logic [2:0]                    REGA_ADDRX,
    output logic [1:0]                    REGB_ADDRX,
    output logic [OPX_W-1:0]              ALU_OPX,
    output logic [1:0]                    ALUA_SRCX,
    output logic [2:0]                    ALUB_SRCX,
    output logic                          CCL_LD,
    output logic [ARG_W-1:0]              ARGA_X,
    output logic [ARG_W-1:0]              ARGB_X,
    output logic                          ILLEGAL,
    output logic                          TIMEOUT
);

    localparam int unsigned INSTR_W = 2 + OPX_W + 2 + 2 * ARG_W;

    seq_state_e         state_q;
    logic [3:0]         phase_q;
    logic [INSTR_W-1:0] instr_q;
    ctrl_t              ctrl_q;
    logic [OPX_W-1:0]   alu_opx_q;
    logic [ARG_W-1:0]   arga_q, argb_q;
    logic               wen_pend_q, ccl_pend_q;
    logic               illegal_q, timeout_q;

    // Fields of the latched word
    logic [1:0]       grp, mode;
    logic [OPX_W-1:0] opx;
    logic [ARG_W-1:0] arga, argb;

    assign grp  = instr_q[INSTR_W-1 -: 2];
    assign opx  = instr_q[INSTR_W-3 -: OPX_W];
    assign mode = instr_q[2*ARG_W+1 -: 2];
    assign arga = instr_q[2*ARG_W-1 -: ARG_W];
    assign argb = instr_q[ARG_W-1:0];

    logic [2:0] dec_alub_srcx, dec_rega_addrx;
    logic       dec_regb_en, dec_rega_wen, dec_ccl_ld;

    alu_mode_decode #(
        .OPX_W   (OPX_W),
        .CMP_OPX (CMP_OPX)
    ) u_mode_decode (
        .mode       (mode),
        .opx        (opx),
        .alub_srcx  (dec_alub_srcx),
        .rega_addrx (dec_rega_addrx),
        .regb_en    (dec_regb_en),
        .rega_wen   (dec_rega_wen),
        .ccl_ld     (dec_ccl_ld)
    );

    logic busy, wait_done;

`ifdef ALU_MULTICYCLE_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    assign busy      = ALU_BUSY;
    assign wait_done = (wait_cnt_q == CNT_W'(MAX_WAIT));
`else
    logic unused_cfg;

    assign busy       = 1'b0;
    assign wait_done  = 1'b0;
    assign unused_cfg = ALU_BUSY | (MAX_WAIT == 0);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StFetch;
            phase_q    <= PhFetch;
            instr_q    <= '0;
            ctrl_q     <= '0;
            alu_opx_q  <= '0;
            arga_q     <= '0;
            argb_q     <= '0;
            wen_pend_q <= 1'b0;
            ccl_pend_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ALU_MULTICYCLE_EN
            wait_cnt_q <= '0;
`endif
        end else if (!STALL) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ALU_MULTICYCLE_EN
            // Counts WAIT cycles; any other state leaves it cleared for the next wait.
            wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + CNT_W'(1) : '0;
`endif
            unique case (state_q)
                StFetch: begin
                    if (INSTR_VALID) begin
                        instr_q   <= INSTRUCTION;
                        // Flag the group at acceptance so ILLEGAL lines up with DECODE.
                        illegal_q <= !is_alu_group(INSTRUCTION[INSTR_W-1 -: 2]);
                        state_q   <= StDecode;
                        phase_q   <= PhDecode;
                    end
                end
                StDecode: begin
                    if (is_alu_group(grp)) begin
                        state_q           <= StExecute;
                        phase_q           <= PhExecute;
                        ctrl_q.rega_en    <= 1'b1;
                        ctrl_q.regb_en    <= dec_regb_en;
                        ctrl_q.rega_wen   <= 1'b0;
                        ctrl_q.ccl_ld     <= 1'b0;
                        ctrl_q.rega_addrx <= dec_rega_addrx;
                        ctrl_q.regb_addrx <= dec_regb_en ? REGB_ADDRX_RB : REGB_ADDRX_NONE;
                        ctrl_q.alua_srcx  <= ALUA_SRCX_REG_A;
                        ctrl_q.alub_srcx  <= dec_alub_srcx;
                        alu_opx_q         <= opx;
                        arga_q            <= arga;
                        argb_q            <= argb;
                        wen_pend_q        <= dec_rega_wen;
                        ccl_pend_q        <= dec_ccl_ld;
                    end else begin
                        state_q <= StFetch;
                        phase_q <= PhFetch;
                    end
                end
                StExecute, StWait: begin
                    if (!busy) begin
                        state_q           <= StCommit;
                        phase_q           <= PhCommit;
                        ctrl_q.regb_en    <= 1'b0;
                        ctrl_q.regb_addrx <= REGB_ADDRX_NONE;
                        ctrl_q.rega_wen   <= wen_pend_q;
                        ctrl_q.ccl_ld     <= ccl_pend_q;
                    end else if (state_q == StWait && wait_done) begin
                        state_q   <= StFetch;
                        phase_q   <= PhFetch;
                        ctrl_q    <= '0;
                        alu_opx_q <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StCommit: begin
                    state_q   <= StFetch;
                    phase_q   <= PhFetch;
                    ctrl_q    <= '0;
                    alu_opx_q <= '0;
                end
                default: begin
                    state_q   <= StFetch;
                    phase_q   <= PhFetch;
                    ctrl_q    <= '0;
                    alu_opx_q <= '0;
                end
            endcase
        end
    end

    // Ready is the registered FETCH phase, gated so a stall can never accept.
    assign INSTR_READY = phase_q[3] & ~STALL;
    assign FETCH       = phase_q[3];
    assign DECODE      = phase_q[2];
    assign EXECUTE     = phase_q[1];
    assign COMMIT      = phase_q[0];
    assign REGA_EN     = ctrl_q.rega_en;
    assign REGB_EN     = ctrl_q.regb_en;
    assign REGA_WEN    = ctrl_q.rega_wen;
    assign REGB_WEN    = 1'b0;
    assign REGA_ADDRX  = ctrl_q.rega_addrx;
    assign REGB_ADDRX  = ctrl_q.regb_addrx;
    assign ALU_OPX     = alu_opx_q;
    assign ALUA_SRCX   = ctrl_q.alua_srcx;
    assign ALUB_SRCX   = ctrl_q.alub_srcx;
    assign CCL_LD      = ctrl_q.ccl_ld;
    assign ARGA_X      = arga_q;
    assign ARGB_X      = argb_q;
    assign ILLEGAL     = illegal_q;
    assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_alu_group_sequencer.sv
module tb_alu_group_sequencer;
    import alu_group_sequencer_pkg::*;

    logic        clk, rst;
    logic [15:0] INSTRUCTION;
    logic        INSTR_VALID, INSTR_READY, STALL, ALU_BUSY;
    logic        FETCH, DECODE, EXECUTE, COMMIT;
    logic        REGA_EN, REGB_EN, REGA_WEN, REGB_WEN, CCL_LD, ILLEGAL, TIMEOUT;
    logic [2:0]  REGA_ADDRX, ALUB_SRCX;
    logic [1:0]  REGB_ADDRX, ALUA_SRCX;
    logic [3:0]  ALU_OPX, ARGA_X, ARGB_X;

    alu_group_sequencer dut (
        .CLK         (clk),
        .RESET       (rst),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .STALL       (STALL),
        .ALU_BUSY    (ALU_BUSY),
        .FETCH       (FETCH),
        .DECODE      (DECODE),
        .EXECUTE     (EXECUTE),
        .COMMIT      (COMMIT),
        .REGA_EN     (REGA_EN),
        .REGB_EN     (REGB_EN),
        .REGA_WEN    (REGA_WEN),
        .REGB_WEN    (REGB_WEN),
        .REGA_ADDRX  (REGA_ADDRX),
        .REGB_ADDRX  (REGB_ADDRX),
        .ALU_OPX     (ALU_OPX),
        .ALUA_SRCX   (ALUA_SRCX),
        .ALUB_SRCX   (ALUB_SRCX),
        .CCL_LD      (CCL_LD),
        .ARGA_X      (ARGA_X),
        .ARGB_X      (ARGB_X),
        .ILLEGAL     (ILLEGAL),
        .TIMEOUT     (TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decode of one instruction word
    typedef struct packed {
        logic       ill;
        logic       regb;
        logic [2:0] alub;
        logic [2:0] ra;
        logic       wen;
        logic       ccl;
    } exp_t;

    typedef struct {
        logic [15:0] w;
        exp_t        e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [15:0] mk(input logic [1:0] g, input logic [3:0] o,
                                       input logic [1:0] m, input logic [3:0] a,
                                       input logic [3:0] b);
        return {g, o, m, a, b};
    endfunction

    function automatic exp_t mke(input logic ill, input logic regb, input logic [2:0] alub,
                                 input logic [2:0] ra, input logic wen, input logic ccl);
        return {ill, regb, alub, ra, wen, ccl};
    endfunction

    // Reference: what the ALU group rules say each word should do.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        e      = '0;
        e.ill  = (w[15:14] != GROUP_ARITHMETIC_LOGIC);
        e.ra   = REGA_ADDRX_RA;
        e.wen  = (w[13:10] != ALU_OPX_CMP);
        e.ccl  = (w[13:10] != ALU_OPX_MOV);
        case (w[9:8])
            MODE_ALU_REG_REG:   begin e.regb = 1'b1; e.alub = ALUB_SRCX_REG_B; end
            MODE_ALU_REG_U4:    begin e.alub = ALUB_SRCX_U4; end
            MODE_ALU_REGB_U8:   begin e.alub = ALUB_SRCX_U8; e.ra = REGA_ADDRX_RB; end
            default:            begin e.regb = 1'b1; e.alub = ALUB_SRCX_U8H; end
        endcase
        return e;
    endfunction

    // Full 4-cycle transaction starting from an idle FETCH cycle at a negedge.
    task automatic do_txn(input logic [15:0] w, input exp_t e);
        logic [3:0] opx;
        logic [1:0] rbx;
        opx = w[13:10];
        rbx = e.regb ? REGB_ADDRX_RB : REGB_ADDRX_NONE;
        chk("idle", {FETCH, DECODE, EXECUTE, COMMIT, INSTR_READY}, 5'b10001);
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        cyc();
        INSTR_VALID = 1'b0;
        INSTRUCTION = 16'($urandom);
        chk("decode", {FETCH, DECODE, EXECUTE, COMMIT, INSTR_READY, ILLEGAL,
                       REGA_EN, REGB_EN, REGA_WEN, CCL_LD}, {5'b01000, e.ill, 4'b0000});
        if (e.ill) begin
            cyc();
            chk("illegal_ret", {FETCH, INSTR_READY, ILLEGAL, REGA_EN, REGB_EN, REGA_WEN,
                                CCL_LD, TIMEOUT}, 8'b11000000);
            return;
        end
        cyc();
        chk("execute", {EXECUTE, COMMIT, REGA_EN, REGB_EN, REGA_WEN, REGB_WEN, CCL_LD,
                        ALU_OPX, ALUA_SRCX, ALUB_SRCX, REGA_ADDRX, REGB_ADDRX, ARGA_X, ARGB_X},
            {2'b10, 1'b1, e.regb, 3'b000, opx, ALUA_SRCX_REG_A, e.alub, e.ra, rbx,
             w[7:4], w[3:0]});
        cyc();
        chk("commit", {EXECUTE, COMMIT, REGA_EN, REGB_EN, REGA_WEN, REGB_WEN, CCL_LD,
                       ALU_OPX, ALUA_SRCX, ALUB_SRCX, REGA_ADDRX},
            {2'b01, 2'b10, e.wen, 1'b0, e.ccl, opx, ALUA_SRCX_REG_A, e.alub, e.ra});
        cyc();
        chk("done", {FETCH, INSTR_READY, REGA_EN, REGB_EN, REGA_WEN, CCL_LD, TIMEOUT,
                     ARGA_X, ARGB_X}, {2'b11, 5'b00000, w[7:4], w[3:0]});
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {FETCH, DECODE, EXECUTE, COMMIT, INSTR_READY, REGA_EN, REGB_EN, REGA_WEN,
                   REGB_WEN, CCL_LD, ILLEGAL, TIMEOUT, REGA_ADDRX, REGB_ADDRX, ALU_OPX,
                   ALUA_SRCX, ALUB_SRCX, ARGA_X, ARGB_X}, {5'b10001, 29'd0});
    endtask

    vec_t        tbl[8];
    logic [15:0] w;
    exp_t        e;
    int          seen;
    logic        wen_seen;

    initial begin
        rst = 1'b1;
        STALL = 1'b0;
        ALU_BUSY = 1'b0;
        INSTR_VALID = 1'b0;
        INSTRUCTION = '0;

        tbl[0] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_AND, MODE_ALU_REG_REG, 4'd5, 4'd1),
                   mke(0, 1, ALUB_SRCX_REG_B, REGA_ADDRX_RA, 1, 1)};
        tbl[1] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_AND, MODE_ALU_REG_U4, 4'd6, 4'd7),
                   mke(0, 0, ALUB_SRCX_U4, REGA_ADDRX_RA, 1, 1)};
        tbl[2] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_AND, MODE_ALU_REGB_U8, 4'hA, 4'h5),
                   mke(0, 0, ALUB_SRCX_U8, REGA_ADDRX_RB, 1, 1)};
        tbl[3] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_MOV, MODE_ALU_REGA_U8RB, 4'hA, 4'h5),
                   mke(0, 1, ALUB_SRCX_U8H, REGA_ADDRX_RA, 1, 0)};
        tbl[4] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_CMP, MODE_ALU_REG_REG, 4'd2, 4'd3),
                   mke(0, 1, ALUB_SRCX_REG_B, REGA_ADDRX_RA, 0, 1)};
        tbl[5] = '{mk(2'b10, ALU_OPX_AND, MODE_ALU_REG_REG, 4'd1, 4'd2),
                   mke(1, 0, ALUB_SRCX_NONE, REGA_ADDRX_NONE, 0, 0)};
        tbl[6] = '{mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_CMP, MODE_ALU_REG_U4, 4'd4, 4'hF),
                   mke(0, 0, ALUB_SRCX_U4, REGA_ADDRX_RA, 0, 1)};
        tbl[7] = '{mk(2'b00, ALU_OPX_ADD, MODE_ALU_REG_U4, 4'd9, 4'd9),
                   mke(1, 0, ALUB_SRCX_NONE, REGA_ADDRX_NONE, 0, 0)};

        repeat (2) cyc();
        chk_reset_state("reset_held");
        rst = 1'b0;
        cyc();
        chk_reset_state("after_reset");

        for (int i = 0; i < 8; i++) do_txn(tbl[i].w, tbl[i].e);

        // Stall while idle: not ready and the offered word is not taken.
        w = mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_XOR, MODE_ALU_REG_REG, 4'd3, 4'd4);
        STALL = 1'b1;
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        #1;
        chk("stall_ready", {INSTR_READY}, 1'b0);
        cyc();
        cyc();
        chk("stall_fetch", {FETCH, DECODE}, 2'b10);
        STALL = 1'b0;
        INSTR_VALID = 1'b0;
        #1;
        do_txn(w, model(w));

        // Stall for three cycles in EXECUTE delays COMMIT by exactly three cycles.
        w = mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_OR, MODE_ALU_REG_U4, 4'd3, 4'd9);
        e = model(w);
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        cyc();
        INSTR_VALID = 1'b0;
        cyc();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold", {EXECUTE, COMMIT, INSTR_READY, REGA_EN, REGB_EN, REGA_WEN,
                               CCL_LD, ALUB_SRCX, ALU_OPX},
                {3'b100, 1'b1, e.regb, 2'b00, e.alub, w[13:10]});
        end
        STALL = 1'b0;
        cyc();
        chk("stall_commit", {COMMIT, REGA_WEN, CCL_LD}, {1'b1, e.wen, e.ccl});
        cyc();
        chk("stall_done", {FETCH, REGA_EN}, 2'b10);

        // Reset during COMMIT drops the write enable at once.
        w = mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_ADD, MODE_ALU_REG_REG, 4'd2, 4'd4);
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        cyc();
        INSTR_VALID = 1'b0;
        cyc();
        cyc();
        chk("pre_reset_commit", {COMMIT, REGA_WEN}, 2'b11);
        rst = 1'b1;
        #1;
        chk_reset_state("reset_in_commit");
        cyc();
        rst = 1'b0;
        cyc();

`ifdef ALU_MULTICYCLE_EN
        // Five busy cycles: COMMIT lands at N+8.
        w = mk(GROUP_ARITHMETIC_LOGIC, ALU_OPX_SUB, MODE_ALU_REG_REG, 4'd1, 4'd2);
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        cyc();
        INSTR_VALID = 1'b0;
        ALU_BUSY = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            cyc();
            chk("busy_wait", {EXECUTE, COMMIT, REGA_EN, REGA_WEN}, 4'b1010);
            if (k == 7) ALU_BUSY = 1'b0;
        end
        cyc();
        chk("busy_commit", {COMMIT, REGA_WEN, CCL_LD}, 3'b111);
        cyc();

        // ALU stuck busy: abort after MAX_WAIT+1 wait cycles, no writeback.
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        cyc();
        INSTR_VALID = 1'b0;
        ALU_BUSY = 1'b1;
        seen = 0;
        wen_seen = 1'b0;
        for (int k = 2; k <= 40 && seen == 0; k++) begin
            cyc();
            if (REGA_WEN) wen_seen = 1'b1;
            if (TIMEOUT) begin
                seen = k;
                chk("timeout_fetch", {FETCH, COMMIT, REGA_EN}, 3'b100);
            end
        end
        chk("timeout_cycle", 64'(seen), 64'd19);
        chk("timeout_no_wen", {wen_seen}, 1'b0);
        ALU_BUSY = 1'b0;
        cyc();
        chk("timeout_pulse", {TIMEOUT, FETCH, INSTR_READY}, 3'b011);
`endif

        // Randomized words checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            int idle;
            logic [1:0] g;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                INSTRUCTION = 16'($urandom);
                cyc();
            end
            g = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : GROUP_ARITHMETIC_LOGIC;
            w = {g, 14'($urandom)};
`ifndef ALU_MULTICYCLE_EN
            ALU_BUSY = 1'($urandom);
`endif
            do_txn(w, model(w));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_group_sequencer.md
# alu_group_sequencer

Parametrised successor to the ALU group decoder. It owns its own FETCH/DECODE/EXECUTE/COMMIT phase sequencer and accepts instructions over a valid/ready handshake. It decodes ARITHMETIC_LOGIC group instructions into register-file, ALU-source and condition-code controls, and supports STALL, compare-without-writeback and an optional multi-cycle ALU wait state. It sits between the instruction fetch unit and the control multiplexer.

## Interface
Parameters:
- OPX_W, 4: ALU opcode width.
- ARG_W, 4: width of each argument field.
- CMP_OPX, `ALU_OPX_CMP: opcode that sets flags without writeback.
- MAX_WAIT, 15: maximum ALU busy cycles before abort. Only used with ALU_MULTICYCLE_EN.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTRUCTION  in  2+OPX_W+2+2*ARG_W  group[MSB:MSB-1], opx, mode[2], argA, argB.
- INSTR_VALID  in  1  instruction word is valid.
- INSTR_READY  out  1  sequencer can accept an instruction.
- STALL  in  1  freeze sequencer and hold all outputs.
- ALU_BUSY  in  1  ALU still computing. Used only with ALU_MULTICYCLE_EN.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase flags.
- REGA_EN, REGB_EN, REGA_WEN, REGB_WEN  out  1 each  register-file controls. REGB_WEN is always 0.
- REGA_ADDRX  out  3  port-A address select.
- REGB_ADDRX  out  2  port-B address select.
- ALU_OPX  out  OPX_W  ALU operation.
- ALUA_SRCX  out  2  ALU A-operand source.
- ALUB_SRCX  out  3  ALU B-operand source.
- CCL_LD  out  1  load condition codes.
- ARGA_X, ARGB_X  out  ARG_W each  latched argument fields.
- ILLEGAL  out  1  one-cycle pulse: accepted word was not in the ALU group.
- TIMEOUT  out  1  one-cycle pulse: ALU wait was aborted.

## Operation
- States: FETCH → DECODE → EXECUTE → [WAIT] → COMMIT → FETCH.
- FETCH: INSTR_READY=1. When INSTR_VALID&&INSTR_READY, latch INSTRUCTION and go to DECODE. Otherwise stay in FETCH.
- DECODE: compute the decode from the latched word and register it. Outputs remain 0 except the phase flag. If group≠GROUP_ARITHMETIC_LOGIC, pulse ILLEGAL and return to FETCH.
- EXECUTE: REGA_EN=1, ALU_OPX=opx, ALUA_SRCX=ALUA_SRCX_REG_A. Mode-dependent outputs:
  - MODE_ALU_REG_REG: REGB_EN=1, ALUB_SRCX=REG_B, REGA_ADDRX=RA.
  - MODE_ALU_REG_U4: ALUB_SRCX=U4, REGA_ADDRX=RA.
  - MODE_ALU_REGB_U8: ALUB_SRCX=U8, REGA_ADDRX=RB.
  - MODE_ALU_REGA_U8RB: REGB_EN=1, ALUB_SRCX=U8H, REGA_ADDRX=RA.
- COMMIT:
  - REGA_EN=1.
  - REGA_WEN=1 unless opx==CMP_OPX.
  - CCL_LD=1 unless opx==ALU_OPX_MOV.
  - REGB_EN=0.
  - ALU source and opcode outputs are held.
- After COMMIT, return to FETCH. All enables, WEN and CCL_LD go to 0. ARGA_X/ARGB_X hold their last value.
- STALL=1 in any state: no transition, outputs held, INSTR_READY forced to 0. STALL takes priority over the handshake and over ALU_BUSY.
- Reset at any point: state=FETCH and every output is 0, except FETCH=1 and INSTR_READY=1. The latched instruction is cleared to 0.

## Timing
- Acceptance at edge N. DECODE in cycle N+1. EXECUTE controls valid in N+2. COMMIT in N+3. INSTR_READY again in N+4.
- Throughput: one instruction per 4 cycles without stalls or waits.
- Every control output is registered. None is combinational from an input.
- ILLEGAL is asserted during the DECODE cycle. FETCH follows in the next cycle.
- INSTRUCTION may change freely outside the acceptance edge.

## Configuration
- `ALU_MULTICYCLE_EN` defined:
  - EXECUTE goes to WAIT if ALU_BUSY=1, otherwise directly to COMMIT.
  - WAIT holds the EXECUTE outputs and counts cycles, leaving for COMMIT when ALU_BUSY=0.
  - When the count reaches MAX_WAIT, abort to FETCH without COMMIT and pulse TIMEOUT.
  - The counter is $clog2(MAX_WAIT+1) bits and clears on entering WAIT.
- Undefined: no WAIT state, ALU_BUSY is ignored, and TIMEOUT is tied to 0.

## Structure
- Shared package: group, mode, ALU_OPX, ALUA/ALUB_SRCX and REGA_ADDRX constants, plus the state encoding. All are existing constants.v items; add the state enum and CMP opcode.
- Sub-module alu_mode_decode: combinational mode/opx → source, address-select, REGB_EN, WEN and CCL_LD flags. It is registered by the sequencer in DECODE.

## Test plan
- AND R5,RI, REG_REG, accepted at edge N:
  - N+2: REGA_EN=1, REGB_EN=1, ALUB_SRCX=REG_B, ALU_OPX=AND.
  - N+3: REGA_WEN=1, CCL_LD=1.
  - N+4: all enables 0, INSTR_READY=1.
- AND R6,#7, REG_U4: EXECUTE shows ALUB_SRCX=U4 and REGB_EN=0. COMMIT shows REGA_WEN=1.
- AND #A5, REGB_U8: EXECUTE shows REGA_ADDRX=RB and ALUB_SRCX=U8. Then MOV REGA_U8RB #A5: ALUB_SRCX=U8H, REGB_EN=1, and COMMIT has CCL_LD=0.
- CMP_OPX instruction: COMMIT has REGA_WEN=0 and CCL_LD=1. A group≠ALU word gives ILLEGAL=1 for one cycle in DECODE and no enables.
- STALL raised for 3 cycles in EXECUTE: outputs frozen, COMMIT delayed by exactly 3 cycles. RESET asserted in COMMIT: REGA_WEN drops immediately and FETCH=1.
- With ALU_MULTICYCLE_EN:
  - ALU_BUSY for 5 cycles: COMMIT at N+8.
  - ALU_BUSY held, MAX_WAIT=15: TIMEOUT pulses, REGA_WEN is never asserted, and the sequencer returns to FETCH.
